pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 3-stage (IF/EX/WB) core.
- Watches the EX and WB instructions, data-memory handshake and branch resolution. Decides each cycle whether stages advance, freeze, or take a bubble or squash.
- Complements the EX operand-forwarding logic: it covers the cases forwarding cannot resolve, which are load-use, memory wait and mispredict.

Parameters:
- FLUSH_CYCLES, 1, consecutive cycles flush_if stays high after a mispredict (1..4).
- MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout sets.
- CNT_W, 32, width of performance counters.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- ex_valid  input  1  EX holds a real instruction
- ex_rs1_addr  input  5  EX source 1
- ex_rs2_addr  input  5  EX source 2
- ex_rs1_used  input  1  EX reads rs1
- ex_rs2_used  input  1  EX reads rs2
- ex_br_mispredict  input  1  EX branch/jump resolved against prediction
- wb_rd_addr  input  5  WB destination
- wb_reg_we  input  1  WB writes regfile
- wb_is_load  input  1  WB instruction is a load
- dmem_req  input  1  EX issues a data-memory access
- dmem_ready  input  1  data memory accepts/completes the access this cycle
- stall_if  output  1  hold PC/IF register
- stall_ex  output  1  hold EX register
- stall_wb  output  1  hold WB register
- bubble_wb  output  1  load NOP into WB instead of the EX instruction
- flush_if  output  1  squash instruction entering EX
- pc_redirect  output  1  select resolved branch target as next PC
- ctrl_state  output  2  current state encoding: RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3
- mem_timeout  output  1  sticky error
- lu_cnt, mem_cnt, flush_cnt  output  CNT_W each  performance counters

Behaviour:
- Interface fact: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - state=RUN, counters=0, mem_timeout=0.
  - While rst is high, all stall/bubble/flush/redirect outputs are 0.
- Output timing: stall, bubble, flush and redirect outputs are combinational from state plus inputs, i.e. same-cycle. State and counters are registered.
- Conditions:
  - mw = dmem_req & ~dmem_ready.
  - lu = wb_is_load & wb_reg_we & (wb_rd_addr!=0) & ex_valid & ((ex_rs1_used & rs1==rd) | (ex_rs2_used & rs2==rd)).
  - mp = ex_valid & ex_br_mispredict.
  - Priority in RUN: mw > lu > mp. A branch depending on a load must wait, because its mispredict flag is invalid.
- RUN:
  - mw: stall_if=stall_ex=stall_wb=1, next state MEM_WAIT, timeout counter cleared.
  - lu: stall_if=stall_ex=1, bubble_wb=1, next state LU_STALL. The load retires to the regfile this cycle. The held EX instruction re-reads operands next cycle through regfile write-before-read.
  - mp: pc_redirect=1, flush_if=1. If FLUSH_CYCLES>1, go to FLUSH with remaining count FLUSH_CYCLES-1; otherwise stay in RUN.
  - None of the above: all outputs 0.
- LU_STALL:
  - Exactly 1 cycle.
  - Outputs 0 except as re-evaluated for mw/mp using RUN rules; lu is not re-evaluated.
  - Next state is RUN, or as dictated by mw/mp.
- MEM_WAIT:
  - stall_if/ex/wb held at 1 while dmem_ready=0.
  - In the cycle dmem_ready=1, all stalls drop to 0 and the state returns to RUN.
  - A mispredict in the frozen EX remains asserted and is acted on the cycle after release, in RUN.
  - The timeout counter increments each waiting cycle and saturates. On reaching MEM_TIMEOUT, mem_timeout sets and stays set until rst. Waiting continues.
- FLUSH:
  - flush_if=1 and pc_redirect=0.
  - The count decrements each cycle; at 1 the state returns to RUN.
  - lu and mp are ignored. ex_valid is 0 for squashed instructions.
  - mw has priority: it freezes the pipe, goes to MEM_WAIT and discards the remaining flush count.
- Reset mid-operation: any state returns to RUN on the next edge. The pending flush count and timeout count are discarded.
- wb_rd_addr==0 never causes a load-use stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: counters wrap modulo 2^CNT_W and reset to 0.
  - lu_cnt +1 per lu stall entry.
  - mem_cnt +1 per cycle with stall_wb=1.
  - flush_cnt +1 per pc_redirect pulse.
- Undefined: counter logic is absent and lu_cnt/mem_cnt/flush_cnt are tied to 0.

Test Plan:
- Load-use: WB load x5 (wb_is_load=1, we=1); EX add reading rs1=x5 -> cycle 0: stall_if=stall_ex=bubble_wb=1, ctrl_state next=1; cycle 1: all 0, state RUN; lu_cnt=1.
- x0 load: WB load with rd=x0; EX reads x0 -> no stall, all outputs 0.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> stall_if/ex/wb=1 for 3 cycles, 0 on the ready cycle; mem_cnt=3; mem_timeout=0.
- Timeout: MEM_TIMEOUT=4, dmem_ready low for 10 cycles -> mem_timeout rises after 4 waiting cycles and stays 1 after ready returns; cleared only by rst=1.
- Mispredict with FLUSH_CYCLES=2 -> cycle 0: pc_redirect=1, flush_if=1; cycle 1: flush_if=1, pc_redirect=0, state FLUSH; cycle 2: all 0, RUN.
- Priority: lu and mp both true in one cycle -> only the load-use stall occurs (pc_redirect=0). Next cycle mp is still high -> pc_redirect=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF/EX/WB core: load-use, memory wait and mispredict handling.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rs1_addr,
  input  logic [4:0]       ex_rs2_addr,
  input  logic             ex_rs1_used,
  input  logic             ex_rs2_used,
  input  logic             ex_br_mispredict,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_reg_we,
  input  logic             wb_is_load,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_ex,
  output logic             stall_wb,
  output logic             bubble_wb,
  output logic             flush_if,
  output logic             pc_redirect,
  output logic [1:0]       ctrl_state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mem_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(MEM_TIMEOUT);
  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LU    = 2'd1,
    ST_MEM   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       flush_left_q, flush_left_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic mw, lu, mp;

  assign mw = dmem_req & ~dmem_ready;
  assign lu = wb_is_load & wb_reg_we & (wb_rd_addr != 5'd0) & ex_valid &
              ((ex_rs1_used & (ex_rs1_addr == wb_rd_addr)) |
               (ex_rs2_used & (ex_rs2_addr == wb_rd_addr)));
  assign mp = ex_valid & ex_br_mispredict;

  always_comb begin
    state_d       = state_q;
    flush_left_d  = flush_left_q;
    tmo_cnt_d     = tmo_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_if      = 1'b0;
    stall_ex      = 1'b0;
    stall_wb      = 1'b0;
    bubble_wb     = 1'b0;
    flush_if      = 1'b0;
    pc_redirect   = 1'b0;
    case (state_q)
      ST_RUN, ST_LU: begin
        // A load-use stall lasts one cycle, so lu is not re-armed from ST_LU.
        state_d = ST_RUN;
        if (mw) begin
          {stall_if, stall_ex, stall_wb} = 3'b111;
          state_d   = ST_MEM;
          tmo_cnt_d = '0;
        end else if (lu && state_q == ST_RUN) begin
          stall_if  = 1'b1;
          stall_ex  = 1'b1;
          bubble_wb = 1'b1;
          state_d   = ST_LU;
        end else if (mp) begin
          pc_redirect = 1'b1;
          flush_if    = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d      = ST_FLUSH;
            flush_left_d = FLUSH_INIT;
          end
        end
      end
      ST_MEM: begin
        if (!dmem_ready) begin
          {stall_if, stall_ex, stall_wb} = 3'b111;
          if (tmo_cnt_q < TMO_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_cnt_d == TMO_MAX) mem_timeout_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (mw) begin
          {stall_if, stall_ex, stall_wb} = 3'b111;
          state_d      = ST_MEM;
          tmo_cnt_d    = '0;
          flush_left_d = '0;
        end else begin
          flush_if = 1'b1;
          if (flush_left_q <= 3'd1) begin
            state_d      = ST_RUN;
            flush_left_d = '0;
          end else begin
            flush_left_d = flush_left_q - 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      {stall_if, stall_ex, stall_wb, bubble_wb, flush_if, pc_redirect} = 6'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      flush_left_q  <= '0;
      tmo_cnt_q     <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_left_q  <= flush_left_d;
      tmo_cnt_q     <= tmo_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign ctrl_state  = state_q;
  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // bubble_wb only rises on a load-use stall entry, so it doubles as the entry pulse.
  always_comb begin
    lu_cnt_d    = lu_cnt_q + CNT_W'(bubble_wb);
    mem_cnt_d   = mem_cnt_q + CNT_W'(stall_wb);
    flush_cnt_d = flush_cnt_q + CNT_W'(pc_redirect);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q    <= '0;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      lu_cnt_q    <= lu_cnt_d;
      mem_cnt_q   <= mem_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign lu_cnt    = lu_cnt_q;
  assign mem_cnt   = mem_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign lu_cnt    = '0;
  assign mem_cnt   = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed test-plan sequences followed by random traffic.
module tb_pipeline_hazard_ctrl;
  localparam int FC = 2;
  localparam int MT = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ex_valid, ex_rs1_used, ex_rs2_used, ex_br_mispredict;
  logic [4:0]    ex_rs1_addr, ex_rs2_addr, wb_rd_addr;
  logic          wb_reg_we, wb_is_load, dmem_req, dmem_ready;
  logic          stall_if, stall_ex, stall_wb, bubble_wb, flush_if, pc_redirect;
  logic [1:0]    ctrl_state;
  logic          mem_timeout;
  logic [CW-1:0] lu_cnt, mem_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used), .ex_br_mispredict(ex_br_mispredict),
    .wb_rd_addr(wb_rd_addr), .wb_reg_we(wb_reg_we), .wb_is_load(wb_is_load),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_if(stall_if), .stall_ex(stall_ex), .stall_wb(stall_wb), .bubble_wb(bubble_wb),
    .flush_if(flush_if), .pc_redirect(pc_redirect), .ctrl_state(ctrl_state),
    .mem_timeout(mem_timeout), .lu_cnt(lu_cnt), .mem_cnt(mem_cnt), .flush_cnt(flush_cnt)
  );

  // ctl bits: {stall_if, stall_ex, stall_wb, bubble_wb, flush_if, pc_redirect}
  typedef struct packed {
    logic [5:0]    ctl;
    logic [1:0]    st;
    logic          tmo;
    logic [CW-1:0] lu;
    logic [CW-1:0] mem;
    logic [CW-1:0] fl;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: mode flags and plain integer counts.
  bit            m_wait, m_lu, m_tmo;
  int            m_fleft, m_waited;
  logic [CW-1:0] c_lu, c_mem, c_fl;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL cycle %0d %s: got %0h want %0h", cyc, name, got, want);
    end
  endtask

  task automatic set_idle();
    ex_valid = 0; ex_rs1_used = 0; ex_rs2_used = 0; ex_br_mispredict = 0;
    ex_rs1_addr = 0; ex_rs2_addr = 0; wb_rd_addr = 0;
    wb_reg_we = 0; wb_is_load = 0; dmem_req = 0; dmem_ready = 1;
  endtask

  task automatic apply();
    exp_t       e;
    logic [5:0] ctl;
    bit         mw, lu, mp, was_lu;
    e.st  = m_wait ? 2'd2 : (m_fleft > 0) ? 2'd3 : (m_lu ? 2'd1 : 2'd0);
    e.tmo = m_tmo;
`ifdef HAZARD_PERF_CNT_EN
    e.lu = c_lu; e.mem = c_mem; e.fl = c_fl;
`else
    e.lu = '0; e.mem = '0; e.fl = '0;
`endif
    ctl = 6'b0;
    if (rst) begin
      m_wait = 0; m_lu = 0; m_tmo = 0; m_fleft = 0; m_waited = 0;
      c_lu = '0; c_mem = '0; c_fl = '0;
    end else begin
      mw = dmem_req && !dmem_ready;
      lu = wb_is_load && wb_reg_we && wb_rd_addr != 0 && ex_valid &&
           ((ex_rs1_used && ex_rs1_addr == wb_rd_addr) || (ex_rs2_used && ex_rs2_addr == wb_rd_addr));
      mp = ex_valid && ex_br_mispredict;
      if (m_wait) begin
        if (!dmem_ready) begin
          ctl = 6'b111000;
          m_waited++;
          if (m_waited >= MT) m_tmo = 1;
        end else begin
          m_wait = 0;
        end
      end else if (m_fleft > 0) begin
        if (mw) begin
          ctl = 6'b111000; m_wait = 1; m_waited = 0; m_fleft = 0;
        end else begin
          ctl = 6'b000010; m_fleft--;
        end
      end else begin
        was_lu = m_lu;
        m_lu   = 0;
        if (mw) begin
          ctl = 6'b111000; m_wait = 1; m_waited = 0;
        end else if (lu && !was_lu) begin
          ctl = 6'b110100; m_lu = 1; c_lu++;
        end else if (mp) begin
          ctl = 6'b000011; c_fl++; m_fleft = FC - 1;
        end
      end
      if (ctl[3]) c_mem++;
    end
    e.ctl = ctl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("ctrl", 32'({stall_if, stall_ex, stall_wb, bubble_wb, flush_if, pc_redirect}), 32'(mon_e.ctl));
      chk("state", 32'(ctrl_state), 32'(mon_e.st));
      chk("mem_timeout", 32'(mem_timeout), 32'(mon_e.tmo));
      chk("lu_cnt", 32'(lu_cnt), 32'(mon_e.lu));
      chk("mem_cnt", 32'(mem_cnt), 32'(mon_e.mem));
      chk("flush_cnt", 32'(flush_cnt), 32'(mon_e.fl));
      cyc++;
    end
  end

  initial begin
    set_idle();
    rst = 1;
    @(posedge clk);
    #1;
    // Reset holds outputs low even with hazards presented.
    dmem_req = 1; dmem_ready = 0; ex_valid = 1; ex_br_mispredict = 1;
    repeat (2) apply();
    rst = 0;
    set_idle();
    apply();
    // Load-use on rs1 = x5
    wb_is_load = 1; wb_reg_we = 1; wb_rd_addr = 5; ex_valid = 1; ex_rs1_used = 1; ex_rs1_addr = 5;
    apply();
    set_idle(); apply(); apply();
    // Load to x0 never stalls
    wb_is_load = 1; wb_reg_we = 1; wb_rd_addr = 0; ex_valid = 1; ex_rs1_used = 1; ex_rs2_used = 1;
    apply();
    set_idle(); apply();
    // Memory wait for three cycles
    dmem_req = 1; dmem_ready = 0;
    repeat (3) apply();
    dmem_ready = 1; apply();
    set_idle(); apply();
    // Timeout: ten waiting cycles, flag survives release until reset
    dmem_req = 1; dmem_ready = 0;
    repeat (10) apply();
    dmem_ready = 1; apply();
    set_idle(); repeat (2) apply();
    rst = 1; apply();
    rst = 0; apply();
    // Mispredict with two flush cycles
    ex_valid = 1; ex_br_mispredict = 1; apply();
    set_idle(); repeat (2) apply();
    // Load-use beats mispredict, mispredict taken next cycle
    wb_is_load = 1; wb_reg_we = 1; wb_rd_addr = 7; ex_valid = 1; ex_rs2_used = 1; ex_rs2_addr = 7;
    ex_br_mispredict = 1;
    apply(); apply();
    set_idle(); repeat (2) apply();
    // Memory request during a flush cycle
    ex_valid = 1; ex_br_mispredict = 1; apply();
    set_idle(); dmem_req = 1; dmem_ready = 0; repeat (2) apply();
    dmem_ready = 1; apply();
    set_idle(); apply();
    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst              = ($urandom_range(0, 59) == 0);
      ex_valid         = ($urandom_range(0, 3) != 0);
      ex_rs1_addr      = 5'($urandom_range(0, 3));
      ex_rs2_addr      = 5'($urandom_range(0, 3));
      ex_rs1_used      = 1'($urandom);
      ex_rs2_used      = 1'($urandom);
      ex_br_mispredict = ($urandom_range(0, 5) == 0);
      wb_rd_addr       = 5'($urandom_range(0, 3));
      wb_reg_we        = ($urandom_range(0, 3) != 0);
      wb_is_load       = 1'($urandom);
      dmem_req         = ($urandom_range(0, 3) == 0);
      dmem_ready       = 1'($urandom);
      apply();
    end
    rst = 0;
    set_idle();
    apply();
    @(posedge clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
